// File: rtl/omsp_spm_cmd_seq.sv
// omsp_spm_cmd_seq: sequences protect/unprotect/verify commands into one-cycle SPM
// control strobes and streams the derived module key into a freshly protected SPM.
`default_nettype none

module omsp_spm_cmd_seq #(
  parameter int KEY_IDX_SIZE = 2,
  parameter int KEY_WORDS    = 4,
  parameter int TO_WIDTH     = 8,
  parameter int TIMEOUT      = 200
) (
  input  logic                    mclk,
  input  logic                    puc_rst,
  input  logic                    cmd_valid,
  input  logic [1:0]              cmd_op,
  output logic                    cmd_ready,
  output logic                    cmd_done,
  output logic                    cmd_error,
  output logic                    busy,
  input  logic                    violation,
  input  logic                    key_word_valid,
  input  logic [15:0]             key_word,
  output logic                    key_word_ack,
  output logic                    update_spm,
  output logic                    enable_spm,
  output logic                    disable_spm,
  output logic                    cancel_spm,
  output logic                    verify_spm,
  output logic                    write_key,
  output logic [15:0]             key_in,
  output logic [KEY_IDX_SIZE-1:0] key_idx
);

  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_ALLOC  = 4'd1,
    S_ACHK   = 4'd2,
    S_KEY    = 4'd3,
    S_CANCEL = 4'd4,
    S_DIS    = 4'd5,
    S_VER    = 4'd6,
    S_VCHK   = 4'd7,
    S_DONE   = 4'd8
  } state_t;

  state_t                  r_state, w_nxt;
  logic [KEY_IDX_SIZE-1:0] r_idx, w_idx_nxt;
  logic [TO_WIDTH-1:0]     r_to, w_to_nxt;
  logic                    r_err, w_err_nxt;
  logic                    r_ready, r_busy, r_done, r_error;
  logic                    r_update, r_enable, r_disable, r_cancel, r_verify;
  logic                    w_accept, w_last, w_to_hit, w_write;

  assign w_accept = cmd_valid & r_ready;
  assign w_last   = (r_idx == KEY_IDX_SIZE'(KEY_WORDS - 1));
  assign w_to_hit = (r_to == TO_WIDTH'(TIMEOUT - 1));
  // Key transfer is combinational so a presented word is consumed in the cycle it appears.
  assign w_write  = (r_state == S_KEY) & key_word_valid;

  always_comb begin
    w_nxt     = r_state;
    w_idx_nxt = r_idx;
    w_to_nxt  = r_to;
    w_err_nxt = r_err;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_op)
            2'b00:   w_nxt = S_ALLOC;
            2'b01:   w_nxt = S_DIS;
            2'b10:   w_nxt = S_VER;
            default: begin
              w_nxt     = S_DONE;
              w_err_nxt = 1'b1;
            end
          endcase
        end
      end
      S_ALLOC: w_nxt = S_ACHK;
      S_ACHK: begin
        if (violation) begin
          w_nxt = S_CANCEL;
        end else begin
          w_nxt     = S_KEY;
          w_idx_nxt = '0;
          w_to_nxt  = '0;
        end
      end
      S_KEY: begin
        // A word arriving on the last timeout cycle still wins over the abort.
        if (key_word_valid) begin
          w_to_nxt = '0;
          if (w_last) begin
            w_nxt     = S_DONE;
            w_err_nxt = 1'b0;
          end else begin
            w_idx_nxt = r_idx + KEY_IDX_SIZE'(1);
          end
        end else begin
          w_to_nxt = r_to + TO_WIDTH'(1);
          if (w_to_hit) w_nxt = S_CANCEL;
        end
      end
      S_CANCEL: begin
        w_nxt     = S_DONE;
        w_err_nxt = 1'b1;
      end
      S_DIS: begin
        w_nxt     = S_DONE;
        w_err_nxt = 1'b0;
      end
      S_VER:  w_nxt = S_VCHK;
      S_VCHK: begin
        w_nxt     = S_DONE;
        w_err_nxt = violation;
      end
      S_DONE:  w_nxt = S_IDLE;
      default: w_nxt = S_IDLE;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state they belong to.
  always_ff @(posedge mclk or posedge puc_rst) begin
    if (puc_rst) begin
      r_state   <= S_IDLE;
      r_idx     <= '0;
      r_to      <= '0;
      r_err     <= 1'b0;
      r_ready   <= 1'b1;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
      r_update  <= 1'b0;
      r_enable  <= 1'b0;
      r_disable <= 1'b0;
      r_cancel  <= 1'b0;
      r_verify  <= 1'b0;
    end else begin
      r_state   <= w_nxt;
      r_idx     <= w_idx_nxt;
      r_to      <= w_to_nxt;
      r_err     <= w_err_nxt;
      r_ready   <= (w_nxt == S_IDLE);
      r_busy    <= (w_nxt != S_IDLE);
      r_done    <= (w_nxt == S_DONE);
      r_error   <= (w_nxt == S_DONE) & w_err_nxt;
      r_update  <= (w_nxt == S_ALLOC) | (w_nxt == S_CANCEL) | (w_nxt == S_DIS);
      r_enable  <= (w_nxt == S_ALLOC);
      r_disable <= (w_nxt == S_DIS);
      r_cancel  <= (w_nxt == S_CANCEL);
      r_verify  <= (w_nxt == S_VER);
    end
  end

  assign cmd_ready    = r_ready;
  assign busy         = r_busy;
  assign cmd_done     = r_done;
  assign cmd_error    = r_error;
  assign update_spm   = r_update;
  assign enable_spm   = r_enable;
  assign disable_spm  = r_disable;
  assign cancel_spm   = r_cancel;
  assign verify_spm   = r_verify;
  assign write_key    = w_write;
  assign key_word_ack = w_write;
  assign key_in       = w_write ? key_word : 16'h0000;
  assign key_idx      = w_write ? r_idx : '0;

endmodule

`default_nettype wire

// File: tb/tb_omsp_spm_cmd_seq.sv
// Directed bench for omsp_spm_cmd_seq: table of command scenarios plus a mid-command reset sequence.
`default_nettype none

module tb_omsp_spm_cmd_seq;

  logic        mclk = 1'b0;
  logic        puc_rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_op = 2'b00;
  logic        violation = 1'b0;
  logic        key_word_valid = 1'b0;
  logic [15:0] key_word = 16'h0000;
  logic        cmd_ready, cmd_done, cmd_error, busy, key_word_ack;
  logic        update_spm, enable_spm, disable_spm, cancel_spm, verify_spm, write_key;
  logic [15:0] key_in;
  logic [1:0]  key_idx;

  omsp_spm_cmd_seq #(.KEY_IDX_SIZE(2), .KEY_WORDS(4), .TO_WIDTH(8), .TIMEOUT(200)) dut (
    .mclk(mclk), .puc_rst(puc_rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op),
    .cmd_ready(cmd_ready), .cmd_done(cmd_done), .cmd_error(cmd_error), .busy(busy),
    .violation(violation), .key_word_valid(key_word_valid), .key_word(key_word),
    .key_word_ack(key_word_ack), .update_spm(update_spm), .enable_spm(enable_spm),
    .disable_spm(disable_spm), .cancel_spm(cancel_spm), .verify_spm(verify_spm),
    .write_key(write_key), .key_in(key_in), .key_idx(key_idx)
  );

  always #5 mclk = ~mclk;

  // mask bits: [0]update [1]enable [2]disable [3]cancel [4]verify [5]write_key
  typedef struct {
    logic [1:0] op;
    logic       viol;
    int         st_after;
    int         st_len;
    int         lat;
    logic       err;
    logic [5:0] mask;
    int         nwr;
    int         nupd;
  } vec_t;

  vec_t vecs[10];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v, output int lat, output logic err, output logic [5:0] mask,
                     output int nwr, output int nupd, output int werr);
    int          n;
    int          sc;
    logic [15:0] expw;
    n = 0; sc = 0; lat = -1; err = 1'bx; mask = '0; nwr = 0; nupd = 0; werr = 0;
    @(posedge mclk); #1;
    cmd_valid = 1'b1; cmd_op = v.op; violation = v.viol;
    key_word_valid = 1'b1; key_word = 16'h1111;
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
    cmd_op = ~v.op;
    for (int cyc = 1; cyc <= 600; cyc++) begin
      if (v.st_len > 0 && n == v.st_after + 1 && sc < v.st_len) begin
        key_word_valid = 1'b0;
        sc++;
      end else begin
        key_word_valid = 1'b1;
      end
      expw = 16'(32'h1111 * (n + 1));
      key_word = expw;
      @(negedge mclk);
      mask |= {write_key, verify_spm, cancel_spm, disable_spm, enable_spm, update_spm};
      if (update_spm) nupd++;
      if (cmd_ready !== 1'b0 || busy !== 1'b1) werr++;
      if (key_word_ack !== write_key) werr++;
      if (write_key) begin
        if (key_in !== expw || key_idx !== 2'(n)) werr++;
        n++;
        nwr++;
      end else if (key_in !== 16'h0 || key_idx !== 2'b00) begin
        werr++;
      end
      if (!cmd_done && cmd_error) werr++;
      if (cmd_done) begin
        lat = cyc;
        err = cmd_error;
        break;
      end
      @(posedge mclk); #1;
    end
  endtask

  initial begin
    int         lat, nwr, nupd, werr;
    logic       err;
    logic [5:0] mask;
    bit         hit;

    vecs[0] = '{2'b01, 1'b0, 0, 0,   2,   1'b0, 6'b000101, 0, 1};
    vecs[1] = '{2'b00, 1'b0, 0, 0,   7,   1'b0, 6'b100011, 4, 1};
    vecs[2] = '{2'b00, 1'b1, 0, 0,   4,   1'b1, 6'b001011, 0, 2};
    vecs[3] = '{2'b00, 1'b0, 1, 200, 206, 1'b1, 6'b101011, 2, 2};
    vecs[4] = '{2'b00, 1'b0, 1, 199, 206, 1'b0, 6'b100011, 4, 1};
    vecs[5] = '{2'b10, 1'b1, 0, 0,   3,   1'b1, 6'b010000, 0, 0};
    vecs[6] = '{2'b10, 1'b0, 0, 0,   3,   1'b0, 6'b010000, 0, 0};
    vecs[7] = '{2'b11, 1'b0, 0, 0,   1,   1'b1, 6'b000000, 0, 0};
    vecs[8] = '{2'b00, 1'b0, 0, 5,   12,  1'b0, 6'b100011, 4, 1};
    vecs[9] = '{2'b01, 1'b1, 0, 0,   2,   1'b0, 6'b000101, 0, 1};

    repeat (2) @(negedge mclk);
    chk("reset_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_strobes", {update_spm, enable_spm, disable_spm, cancel_spm, verify_spm, write_key}, 0);
    chk("reset_done", {cmd_done, cmd_error}, 0);
    puc_rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run(vecs[i], lat, err, mask, nwr, nupd, werr);
      chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      chk($sformatf("v%0d_error", i), err, vecs[i].err);
      chk($sformatf("v%0d_strobes", i), mask, vecs[i].mask);
      chk($sformatf("v%0d_writes", i), nwr, vecs[i].nwr);
      chk($sformatf("v%0d_updates", i), nupd, vecs[i].nupd);
      chk($sformatf("v%0d_cycle_rules", i), werr, 0);
      @(negedge mclk);
      chk($sformatf("v%0d_ready_after", i), {cmd_ready, busy, cmd_done}, 3'b100);
    end

    // Reset while streaming key word 2; command must vanish without a done pulse.
    @(posedge mclk); #1;
    cmd_valid = 1'b1; cmd_op = 2'b00; violation = 1'b0; key_word_valid = 1'b1; key_word = 16'hABCD;
    @(posedge mclk); #1;
    cmd_valid = 1'b0;
    hit = 1'b0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge mclk);
      if (write_key && key_idx == 2'd2) hit = 1'b1;
    end
    chk("rst_reached_idx2", hit, 1);
    #1 puc_rst = 1'b1;
    #1;
    chk("rst_strobes_clear", {update_spm, enable_spm, disable_spm, cancel_spm, verify_spm, write_key, key_word_ack}, 0);
    chk("rst_key_outputs", {key_in, key_idx}, 0);
    chk("rst_ready", {cmd_ready, busy}, 2'b10);
    hit = 1'b0;
    repeat (2) begin
      @(negedge mclk);
      if (cmd_done) hit = 1'b1;
    end
    puc_rst = 1'b0;
    repeat (3) begin
      @(negedge mclk);
      if (cmd_done) hit = 1'b1;
    end
    chk("rst_no_done", hit, 0);

    run(vecs[1], lat, err, mask, nwr, nupd, werr);
    chk("restart_latency", lat, 7);
    chk("restart_error", err, 0);
    chk("restart_writes", nwr, 4);
    chk("restart_idx_from_0", werr, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/omsp_spm_cmd_seq.md
Name: omsp_spm_cmd_seq

Overview:
Multi-cycle sequencer between the execution unit and the SPM control array for the Sancus management instructions. It accepts one command at a time (protect, unprotect, verify). It drives the one-cycle update/enable/disable/cancel/verify strobes and samples the resulting violation. For protect, it also streams the derived module key, word by word, from the crypto engine into the new SPM.

Parameters:
KEY_IDX_SIZE, 2, width of key_idx.
KEY_WORDS, 4, 16-bit key words per module key (`SECURITY/16); must be <= 2**KEY_IDX_SIZE.
TO_WIDTH, 8, width of the key-wait timeout counter.
TIMEOUT, 200, cycles to wait for each key word before aborting; must be < 2**TO_WIDTH.

Ports:
mclk  input  1  core clock
puc_rst  input  1  asynchronous active-high reset
cmd_valid  input  1  execution unit presents a command
cmd_op  input  2  00 protect, 01 unprotect, 10 verify, 11 reserved
cmd_ready  output  1  high only in IDLE; a command is accepted when cmd_valid & cmd_ready
cmd_done  output  1  one-cycle completion pulse
cmd_error  output  1  valid with cmd_done; 1 = command failed
busy  output  1  high in every state except IDLE
violation  input  1  violation output of the SPM control array
key_word_valid  input  1  crypto engine presents the next key word
key_word  input  16  key word from the crypto engine
key_word_ack  output  1  consumes key_word this cycle
update_spm  output  1  to SPM control
enable_spm  output  1  to SPM control
disable_spm  output  1  to SPM control
cancel_spm  output  1  to SPM control
verify_spm  output  1  to SPM control
write_key  output  1  to SPM control
key_in  output  16  to SPM control
key_idx  output  KEY_IDX_SIZE  to SPM control

Behaviour:
- Reset: puc_rst (asynchronous, active-high) on clock mclk forces IDLE. All outputs reset to 0, except cmd_ready=1. Index and timeout counters reset to 0. Reset asserted mid-command abandons the command; no done pulse is produced.
- All strobes and done/error are Moore outputs decoded from registered state. Each strobe lasts exactly one cycle unless stated otherwise.
- States: IDLE, ALLOC, ACHK, KEY, CANCEL, DIS, VER, VCHK, DONE.
- IDLE: on accept, go to ALLOC for 00, DIS for 01, VER for 10, or DONE with error=1 for 11.
- ALLOC: update_spm=1, enable_spm=1. Next state is ACHK.
- ACHK: sample violation.
  - violation=1: go to CANCEL.
  - violation=0: go to KEY; clear key_idx and the timeout counter.
- KEY: while key_word_valid=0, increment the timeout counter.
  - When the counter reaches TIMEOUT, go to CANCEL.
  - When key_word_valid=1: in the same cycle, write_key=1, key_word_ack=1, key_in=key_word, key_idx=current index. The timeout counter resets.
  - If the index equals KEY_WORDS-1, go to DONE with error=0; otherwise increment the index.
  - Simultaneous valid and timeout: valid wins.
- CANCEL: update_spm=1, cancel_spm=1, enable_spm=0. Go to DONE with error=1. The SPM array rolls back next_id.
- DIS: update_spm=1, disable_spm=1, enable_spm=0. Go to DONE with error=0.
- VER: verify_spm=1. Next state is VCHK.
- VCHK: error latched = violation. Go to DONE.
- DONE: cmd_done=1 and cmd_error=latched error for one cycle. Next state is IDLE.
- cmd_ready is low from the accept cycle+1 through DONE. A new command can be accepted in the cycle after DONE.
- cmd_valid is ignored outside IDLE. cmd_op is sampled only at accept and held internally.
- key_in and key_idx are 0 whenever write_key=0.
- Latency (accept edge to done pulse): unprotect 2 cycles; verify 3 cycles; reserved op 1 cycle; protect 3+KEY_WORDS cycles minimum, plus any wait cycles.

Test Plan:
- Unprotect: cmd_op=01 accepted at cycle 0 -> update_spm=1 and disable_spm=1 at cycle 1; cmd_done=1, cmd_error=0 at cycle 2; cmd_ready=1 at cycle 3.
- Protect, clean: cmd_op=00, violation=0, key_word_valid held high with words 0x1111..0x4444 -> ALLOC at cycle 1; write_key at cycles 3-6 with key_idx 0..3 and matching key_in; cmd_done=1, cmd_error=0 at cycle 7.
- Protect, overlap: violation=1 during ACHK -> no write_key; update_spm=1 and cancel_spm=1 one cycle; then cmd_done=1, cmd_error=1.
- Protect, stalled crypto: key_word_valid low for 200 cycles after idx 1 -> CANCEL strobe, then cmd_error=1. A word arriving at count 199 is accepted instead.
- Verify: violation=1 in VCHK -> verify_spm one cycle, then cmd_done=1, cmd_error=1. Reserved op 11 -> done with error next cycle and no strobes.
- Reset mid-KEY at idx 2 -> all strobes 0 immediately and cmd_ready=1; no cmd_done. A subsequent protect restarts at key_idx 0.
